alu_share_ctrl: RTL and testbench

- Shares the single combinational ALU between two requesters, e.g. port 0 = instruction execute, port 1 = address/branch unit.
- Each port uses a valid/ready request/response handshake.
- Arbitrates between requesters, registers the operands, captures the result and the {C V Z N} flags, and returns them to the winning port.
- Maintains the architectural flags register consumed by conditional-branch logic.

---
 rtl/alu_share_ctrl_pkg.sv | 49 ++++
 rtl/alu_share_ctrl_if.sv | 29 ++
 rtl/alu_share_ctrl_alu.sv | 62 ++++++
 rtl/alu_share_ctrl_arb2.sv | 52 +++++
 rtl/alu_share_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing controller: operand and opcode widths,
// opcode encodings, flag bit positions, controller state encoding and a small
// helper that decides how an opcode affects the architectural flags.
// Optional feature macro used elsewhere in this slice: ALU_SHARE_RR_EN.
package alu_share_ctrl_pkg;

  localparam int opsize   = 4;
  localparam int aluwidth = 8;
  localparam int numflags = 4;
  localparam int NREQ     = 2;

  localparam logic [opsize-1:0] ADD = 4'd0;
  localparam logic [opsize-1:0] SUB = 4'd1;
  localparam logic [opsize-1:0] CMP = 4'd2;
  localparam logic [opsize-1:0] AND = 4'd3;
  localparam logic [opsize-1:0] OR  = 4'd4;
  localparam logic [opsize-1:0] LS  = 4'd5;
  localparam logic [opsize-1:0] RS  = 4'd6;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_UNDEF = 2'd2
  } opclass_t;

  // Arithmetic ops rewrite every flag, logic/shift ops only touch Z and N,
  // and anything unrecognised leaves the architectural flags alone.
  function automatic opclass_t opClass(input logic [opsize-1:0] op);
    opclass_t cls;
    case (op)
      ADD, SUB, CMP:   cls = CLS_ARITH;
      AND, OR, LS, RS: cls = CLS_LOGIC;
      default:         cls = CLS_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bus between the two requesters and the ALU sharing
// controller. The controller connects through the slave modport; a requester
// (or a bench acting as both requesters) uses the master modport.
interface alu_share_ctrl_if;
  import alu_share_ctrl_pkg::*;

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*opsize-1:0]   req_op;
  logic [NREQ*aluwidth-1:0] req_a;
  logic [NREQ*aluwidth-1:0] req_b;
  logic [NREQ-1:0]          rsp_valid;
  logic [NREQ-1:0]          rsp_ready;
  logic [aluwidth-1:0]      rsp_data;
  logic [numflags-1:0]      rsp_flags;
  logic [numflags-1:0]      flags_q;
  logic                     busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, flags_q, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags, flags_q, busy
  );

endinterface

// File: rtl/alu_share_ctrl_alu.sv
// The shared combinational ALU. Produces an aluwidth-bit result and the
// {C V Z N} flags for one operation. Shifts by aluwidth or more give zero,
// CMP reports the difference with C forced low, and unknown opcodes give a
// zero result (hence only Z set).
module alu_share_alu
  import alu_share_ctrl_pkg::*;
(
  input  logic [opsize-1:0]   op_i,
  input  logic [aluwidth-1:0] a_i,
  input  logic [aluwidth-1:0] b_i,
  output logic [aluwidth-1:0] result_o,
  output logic [numflags-1:0] flags_o
);

  localparam int ShW = $clog2(aluwidth);
  localparam logic [aluwidth-1:0] ShiftLimit = aluwidth'(aluwidth);

  logic [aluwidth:0] wide;
  logic              carry;
  logic              ovf;

  // Compute the result first, then derive carry/overflow from the operand and
  // result sign bits; SUB and CMP share the widened subtraction so the borrow
  // falls out as the top bit of the difference.
  always_comb begin
    wide     = '0;
    result_o = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op_i)
      ADD: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[aluwidth-1:0];
        carry    = wide[aluwidth];
        ovf      = (a_i[aluwidth-1] == b_i[aluwidth-1]) &&
                   (result_o[aluwidth-1] != a_i[aluwidth-1]);
      end
      SUB, CMP: begin
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[aluwidth-1:0];
        carry    = (op_i == SUB) ? wide[aluwidth] : 1'b0;
        ovf      = (a_i[aluwidth-1] != b_i[aluwidth-1]) &&
                   (result_o[aluwidth-1] != a_i[aluwidth-1]);
      end
      AND: result_o = a_i & b_i;
      OR:  result_o = a_i | b_i;
      LS:  result_o = (b_i >= ShiftLimit) ? '0 : (a_i << b_i[ShW-1:0]);
      RS:  result_o = (b_i >= ShiftLimit) ? '0 : (a_i >> b_i[ShW-1:0]);
      default: result_o = '0;
    endcase
  end

  // Pack the flags in {C V Z N} order.
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_N] = result_o[aluwidth-1];
  end

endmodule

// File: rtl/alu_share_ctrl_arb2.sv
// Two-input grant generator. With ALU_SHARE_RR_EN defined, a one-bit pointer
// selects the winner when both ports request and moves to the other port
// after every accepted request; a lone requester always wins. Without the
// macro port 0 has fixed priority and no pointer register exists.
module alu_share_arb2 (
`ifdef ALU_SHARE_RR_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       advance_i,
`endif
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

`ifdef ALU_SHARE_RR_EN
  logic ptr_q;

  // After each accepted request the pointer favours the port that did not
  // just win, so two persistent requesters alternate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (advance_i) begin
      ptr_q <= ~grant_idx_o;
    end
  end

  // Contention is resolved by the pointer; otherwise whoever is asking wins.
  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end
`else
  // Port 0 wins whenever it asks; port 1 only gets through when port 0 is idle.
  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end
`endif

  assign grant_idx_o = grant_o[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// ALU sharing controller: arbitrates two requesters onto one ALU, registers
// the operands, captures result and flags, returns them to the winner, and
// keeps the architectural {C V Z N} flags register.
// Grant policy macro: ALU_SHARE_RR_EN (round robin when defined, otherwise
// fixed priority to port 0).
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
(
  input logic             clk,
  input logic             reset,
  alu_share_ctrl_if.slave bus
);

  state_t              state_q;
  logic [opsize-1:0]   op_q;
  logic [aluwidth-1:0] a_q;
  logic [aluwidth-1:0] b_q;
  logic                gntIdx_q;
  logic [NREQ-1:0]     rspValid_q;
  logic [aluwidth-1:0] rspData_q;
  logic [numflags-1:0] rspFlags_q;
  logic [numflags-1:0] archFlags_q;

  logic [1:0]          grant;
  logic                grantIdx;
  logic [NREQ-1:0]     reqReady;
  logic                accept;
  logic [opsize-1:0]   selOp;
  logic [aluwidth-1:0] selA;
  logic [aluwidth-1:0] selB;
  logic [aluwidth-1:0] aluResult;
  logic [numflags-1:0] aluFlags;

  alu_share_arb2 u_arb (
`ifdef ALU_SHARE_RR_EN
    .clk         (clk),
    .reset       (reset),
    .advance_i   (accept),
`endif
    .valid_i     (bus.req_valid),
    .grant_o     (grant),
    .grant_idx_o (grantIdx)
  );

  alu_share_alu u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (aluResult),
    .flags_o  (aluFlags)
  );

  // Only one operation may be outstanding, so the grant is exposed as ready
  // solely while idle; the arbiter never grants a port that is not asking.
  always_comb begin
    reqReady = (state_q == IDLE) ? grant : 2'b00;
    accept   = |reqReady;
  end

  // Steer the granted port's opcode and operands towards the capture registers.
  always_comb begin
    selOp = grantIdx ? bus.req_op[2*opsize-1:opsize]   : bus.req_op[opsize-1:0];
    selA  = grantIdx ? bus.req_a[2*aluwidth-1:aluwidth] : bus.req_a[aluwidth-1:0];
    selB  = grantIdx ? bus.req_b[2*aluwidth-1:aluwidth] : bus.req_b[aluwidth-1:0];
  end

  // Controller FSM. IDLE captures a request on the handshake, EXEC runs the ALU
  // from the captured operands for one cycle and registers its outputs (and the
  // architectural flags), RESP holds the response until the winner consumes it.
  // Reset abandons anything in flight and clears the flags register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gntIdx_q    <= 1'b0;
      rspValid_q  <= '0;
      rspData_q   <= '0;
      rspFlags_q  <= '0;
      archFlags_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= selOp;
            a_q      <= selA;
            b_q      <= selB;
            gntIdx_q <= grantIdx;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rspData_q  <= aluResult;
          rspFlags_q <= aluFlags;
          rspValid_q <= gntIdx_q ? 2'b10 : 2'b01;
          case (opClass(op_q))
            CLS_ARITH: archFlags_q <= aluFlags;
            CLS_LOGIC: begin
              archFlags_q[FLAG_Z] <= aluFlags[FLAG_Z];
              archFlags_q[FLAG_N] <= aluFlags[FLAG_N];
            end
            default: archFlags_q <= archFlags_q;
          endcase
          state_q <= RESP;
        end
        RESP: begin
          if (|(rspValid_q & bus.rsp_ready)) begin
            rspValid_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rspValid_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_data  = rspData_q;
  assign bus.rsp_flags = rspFlags_q;
  assign bus.flags_q   = archFlags_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. Directed scenarios followed by random
// single-port traffic, all compared against an arithmetic reference model.
// Grant expectations follow ALU_SHARE_RR_EN when it is defined for the build.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [3:0] refFlags;
  int   rrMode;

  alu_share_ctrl_if bus();

  alu_share_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the design wedges somewhere the bounded waits miss.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference ALU from the arithmetic definitions using plain integers.
  // cls: 0 = rewrites all flags, 1 = only Z/N, 2 = leaves flags alone.
  function automatic void refAlu(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic [3:0] f, output int cls);
    int ua, ub, sa, sb, full, sfull, res;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; res = 0; cls = 1;
    if (op == ADD) begin
      full = ua + ub; sfull = sa + sb;
      res = full % 256; c = (full > 255); v = (sfull > 127) || (sfull < -128); cls = 0;
    end else if (op == SUB || op == CMP) begin
      full = ua - ub; sfull = sa - sb;
      res = (full + 256) % 256; c = (op == SUB) && (ua < ub);
      v = (sfull > 127) || (sfull < -128); cls = 0;
    end else if (op == AND) res = ua & ub;
    else if (op == OR) res = ua | ub;
    else if (op == LS) res = (ub >= 8) ? 0 : (ua * (1 << ub)) % 256;
    else if (op == RS) res = (ub >= 8) ? 0 : ua / (1 << ub);
    else cls = 2;
    r = 8'(res);
    f = {c, v, (res == 0), (res >= 128)};
  endfunction

  function automatic void refCommit(input int cls, input logic [3:0] f);
    if (cls == 0) refFlags = f;
    else if (cls == 1) refFlags[1:0] = f[1:0];
  endfunction

  // One complete transaction on a single port: request, latency check,
  // optional backpressure with distractions, then consume the response.
  task automatic applyStimulus(input int port, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input int holdCycles);
    int w, cls, other;
    logic [7:0] expData;
    logic [3:0] expFlags;
    other = 1 - port;
    refAlu(op, a, b, expData, expFlags, cls);
    @(negedge clk);
    bus.req_valid[port] = 1'b1;
    bus.req_op[port*4 +: 4] = op;
    bus.req_a[port*8 +: 8] = a;
    bus.req_b[port*8 +: 8] = b;
    #1;
    w = 0;
    while (!bus.req_ready[port] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    checkOutput("accept", 32'(bus.req_ready[port]), 32'd1);
    if (!bus.req_ready[port]) begin
      bus.req_valid = 2'b00;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[port] = 1'b0;
    bus.req_a[port*8 +: 8] = 8'($urandom);
    bus.req_b[port*8 +: 8] = 8'($urandom);
    @(negedge clk);
    checkOutput("execNoRsp", 32'(bus.rsp_valid), 32'd0);
    checkOutput("execBusy", 32'(bus.busy), 32'd1);
    @(posedge clk); @(negedge clk);
    refCommit(cls, expFlags);
    checkOutput("rspValid", 32'(bus.rsp_valid), 32'(2'b01 << port));
    checkOutput("rspData", 32'(bus.rsp_data), 32'(expData));
    checkOutput("rspFlags", 32'(bus.rsp_flags), 32'(expFlags));
    checkOutput("flagsQ", 32'(bus.flags_q), 32'(refFlags));
    if (holdCycles > 0) begin
      bus.req_valid = 2'b11;
      bus.rsp_ready[other] = 1'b1;
    end
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(bus.rsp_valid), 32'(2'b01 << port));
      checkOutput("holdData", 32'(bus.rsp_data), 32'(expData));
      checkOutput("holdFlags", 32'(bus.rsp_flags), 32'(expFlags));
      checkOutput("holdReqReady", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.rsp_ready[port] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[port] = 1'b0;
    @(negedge clk);
    checkOutput("doneValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("doneBusy", 32'(bus.busy), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    refFlags = 4'b0000;
  endtask

  initial begin
    int w, cls, expG, port;
    logic [3:0] op;
    logic [7:0] a, b, expData;
    logic [3:0] expFlags;
    logic [7:0] gA [2];
    logic [7:0] gB [2];
    logic [3:0] gOp [2];

    total = 0;
    bad = 0;
    refFlags = 4'b0000;
`ifdef ALU_SHARE_RR_EN
    rrMode = 1;
`else
    rrMode = 0;
`endif
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", 32'(bus.req_ready), 32'd0);
    checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstRspData", 32'(bus.rsp_data), 32'd0);
    checkOutput("rstRspFlags", 32'(bus.rsp_flags), 32'd0);
    checkOutput("rstFlagsQ", 32'(bus.flags_q), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    $display("[TB] directed ADD/SUB/OR");
    applyStimulus(0, ADD, 8'h7F, 8'h01, 0);
    checkOutput("addFlagsConst", 32'(bus.flags_q), 32'h5);
    applyStimulus(1, SUB, 8'h05, 8'h05, 0);
    checkOutput("subFlagsConst", 32'(bus.flags_q), 32'h2);
    applyStimulus(0, OR, 8'h80, 8'h00, 0);
    checkOutput("orFlagsConst", 32'(bus.flags_q), 32'h1);
    applyStimulus(1, CMP, 8'h10, 8'h20, 0);
    applyStimulus(0, LS, 8'h81, 8'h08, 0);
    applyStimulus(1, RS, 8'h80, 8'h07, 0);
    applyStimulus(0, 4'hB, 8'h12, 8'h34, 0);

    $display("[TB] backpressure");
    applyStimulus(0, ADD, 8'hFF, 8'h01, 5);
    applyStimulus(1, SUB, 8'h00, 8'h01, 3);

    $display("[TB] reset during EXEC");
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_op[3:0] = ADD;
    bus.req_a[7:0] = 8'h7F;
    bus.req_b[7:0] = 8'h01;
    #1;
    w = 0;
    while (!bus.req_ready[0] && w < 20) begin
      @(negedge clk); #1; w++;
    end
    checkOutput("abortAccept", 32'(bus.req_ready[0]), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    refFlags = 4'b0000;
    checkOutput("abortRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("abortRspData", 32'(bus.rsp_data), 32'd0);
    checkOutput("abortRspFlags", 32'(bus.rsp_flags), 32'd0);
    checkOutput("abortFlagsQ", 32'(bus.flags_q), 32'd0);
    checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    checkOutput("abortReqReady", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abortNoRsp", 32'(bus.rsp_valid), 32'd0);
    end
    applyStimulus(0, SUB, 8'h80, 8'h01, 0);

    $display("[TB] contention, rrMode=%0d", rrMode);
    pulseReset();
    gOp[0] = ADD; gA[0] = 8'h10; gB[0] = 8'h20;
    gOp[1] = SUB; gA[1] = 8'h05; gB[1] = 8'h30;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_op = {gOp[1], gOp[0]};
    bus.req_a = {gA[1], gA[0]};
    bus.req_b = {gB[1], gB[0]};
    #1;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (bus.req_ready == 2'b00 && w < 20) begin
        @(negedge clk); #1; w++;
      end
      expG = (rrMode != 0) ? (i % 2) : 0;
      checkOutput("grant", 32'(bus.req_ready), 32'(2'b01 << expG));
      if (bus.req_ready == 2'b00) break;
      refAlu(gOp[expG], gA[expG], gB[expG], expData, expFlags, cls);
      @(posedge clk); @(negedge clk);
      checkOutput("gntExecNoRsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      refCommit(cls, expFlags);
      checkOutput("gntRspValid", 32'(bus.rsp_valid), 32'(2'b01 << expG));
      checkOutput("gntRspData", 32'(bus.rsp_data), 32'(expData));
      checkOutput("gntFlagsQ", 32'(bus.flags_q), 32'(refFlags));
      bus.rsp_ready = 2'b01 << expG;
      @(posedge clk); #1;
      bus.rsp_ready = 2'b00;
      @(negedge clk); #1;
    end
    bus.req_valid = 2'b00;
    pulseReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      port = $urandom_range(0, 1);
      op = 4'($urandom_range(0, 8));
      a = 8'($urandom);
      b = (op == LS || op == RS) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      applyStimulus(port, op, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
